// File: rtl/key_matrix_scanner.sv
// Key matrix scanner: column-strobed scan, single-key debounce, event FIFO and bus registers.
// Optional KEY_RELEASE_EN macro adds release events {1'b1, code} ahead of each accepted change.
module key_matrix_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  input  logic            rd,
  input  logic            wr,
  input  logic [1:0]      addr,
  input  logic [7:0]      wrdat,
  output logic [7:0]      rddat,
  output logic            irq,
  output logic [COLS-1:0] key_col_o,
  input  logic [ROWS-1:0] key_row_i
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic [ROWS-1:0] row_s1_q, row_s2_q;
  logic            run_q;
  logic [SW-1:0]   slot_q, slot_d;
  logic [CW-1:0]   col_q, col_d;
  logic [1:0]      hit_q, hit_d, col_hits, hit_sum;
  logic [6:0]      hit_code_q, hit_code_d, code_now, sum_code;
  logic [2:0]      col_row, hit_tot;
  logic [1:0]      ctrl_q;
  logic            scanning, slot_end, scan_end;

  assign scanning  = ctrl_q[0] & run_q;
  assign slot_end  = scanning && (slot_q == SW'(SCAN_DIV - 1));
  assign scan_end  = slot_end && (col_q == CW'(COLS - 1));
  assign key_col_o = scanning ? ~(COLS'(1) << col_q) : {COLS{1'b1}};

  always_comb begin
    col_hits = 2'd0;
    col_row  = 3'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_s2_q[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_row = 3'(r);
      end
    end
    code_now = 7'(int'(col_row) * COLS + int'(col_q));
    hit_tot  = {1'b0, hit_q} + {1'b0, col_hits};
    hit_sum  = (hit_tot >= 3'd2) ? 2'd2 : hit_tot[1:0];
    sum_code = (col_hits == 2'd1) ? code_now : hit_code_q;
  end

  always_comb begin
    slot_d     = slot_q;
    col_d      = col_q;
    hit_d      = hit_q;
    hit_code_d = hit_code_q;
    if (!scanning) begin
      slot_d = '0;
      col_d  = '0;
      hit_d  = 2'd0;
    end else if (slot_end) begin
      slot_d     = '0;
      col_d      = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
      hit_d      = scan_end ? 2'd0 : hit_sum;
      hit_code_d = sum_code;
    end else begin
      slot_d = slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q   <= '1;
      row_s2_q   <= '1;
      run_q      <= 1'b0;
      slot_q     <= '0;
      col_q      <= '0;
      hit_q      <= 2'd0;
      hit_code_q <= 7'd0;
    end else begin
      row_s1_q   <= key_row_i;
      row_s2_q   <= row_s1_q;
      run_q      <= ctrl_q[0];
      slot_q     <= slot_d;
      col_q      <= col_d;
      hit_q      <= hit_d;
      hit_code_q <= hit_code_d;
    end
  end

  // Debounce: a candidate must repeat for DEBOUNCE full scans before it is accepted.
  logic       cand_valid, same;
  logic       prev_valid_q, prev_valid_d, acc_valid_q, acc_valid_d;
  logic [6:0] prev_code_q, prev_code_d, acc_code_q, acc_code_d;
  logic [3:0] stable_q, stable_d;
  logic       push_req;
  logic [7:0] push_data;
`ifdef KEY_RELEASE_EN
  logic       pend_q, pend_d;
  logic [6:0] pend_code_q, pend_code_d;
`endif

  assign cand_valid = (hit_sum == 2'd1);
  assign same = (cand_valid == prev_valid_q) && (!cand_valid || sum_code == prev_code_q);

  always_comb begin
    prev_valid_d = prev_valid_q;
    prev_code_d  = prev_code_q;
    acc_valid_d  = acc_valid_q;
    acc_code_d   = acc_code_q;
    stable_d     = stable_q;
    push_req     = 1'b0;
    push_data    = 8'h00;
`ifdef KEY_RELEASE_EN
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    if (pend_q) begin
      push_req  = 1'b1;
      push_data = {1'b0, pend_code_q};
    end
`endif
    if (scan_end) begin
      prev_valid_d = cand_valid;
      prev_code_d  = sum_code;
      if (!same) stable_d = 4'd1;
      else if (stable_q != DB) stable_d = stable_q + 4'd1;
      if (stable_d == DB && (cand_valid != acc_valid_q ||
                             (cand_valid && sum_code != acc_code_q))) begin
        acc_valid_d = cand_valid;
        acc_code_d  = sum_code;
`ifdef KEY_RELEASE_EN
        if (acc_valid_q) begin
          push_req    = 1'b1;
          push_data   = {1'b1, acc_code_q};
          pend_d      = cand_valid;
          pend_code_d = sum_code;
        end else if (cand_valid) begin
          push_req  = 1'b1;
          push_data = {1'b0, sum_code};
        end
`else
        if (cand_valid) begin
          push_req  = 1'b1;
          push_data = {1'b0, sum_code};
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid_q <= 1'b0;
      prev_code_q  <= 7'd0;
      acc_valid_q  <= 1'b0;
      acc_code_q   <= 7'd0;
      stable_q     <= 4'd0;
`ifdef KEY_RELEASE_EN
      pend_q       <= 1'b0;
      pend_code_q  <= 7'd0;
`endif
    end else begin
      prev_valid_q <= prev_valid_d;
      prev_code_q  <= prev_code_d;
      acc_valid_q  <= acc_valid_d;
      acc_code_q   <= acc_code_d;
      stable_q     <= stable_d;
`ifdef KEY_RELEASE_EN
      pend_q       <= pend_d;
      pend_code_q  <= pend_code_d;
`endif
    end
  end

  // Bus strobes are edge-qualified so a held strobe acts only once.
  logic          rd_act, wr_act, rd_q, wr_q, rd_fall, wr_rise;
  logic [1:0]    rd_addr_q;
  logic          flush, clr_ovf, push, pop, empty, full, ovf_q, irq_q;
  logic [7:0]    rddat_q, rd_mux, status;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [NW-1:0] cnt_q;
  logic [4:0]    cnt_sat;
  logic          unused_wrdat;

  assign unused_wrdat = ^wrdat[7:2];
  assign rd_act  = cs & rd;
  assign wr_act  = cs & wr;
  assign rd_fall = rd_q & ~rd_act;
  assign wr_rise = wr_act & ~wr_q;
  assign clr_ovf = wr_rise && (addr == 2'd3) && wrdat[0];
  assign flush   = wr_rise && (addr == 2'd3) && wrdat[1];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == NW'(FIFO_DEPTH));
  assign pop     = rd_fall && (rd_addr_q == 2'd0) && !empty && !flush;
  assign push    = push_req && !flush && (!full || pop);
  assign cnt_sat = (int'(cnt_q) > 31) ? 5'd31 : 5'(cnt_q);
  assign status  = {ovf_q, full, empty, cnt_sat};

  always_comb begin
    case (addr)
      2'd0:    rd_mux = empty ? 8'hFF : mem_q[rp_q];
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {6'd0, ctrl_q};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ctrl_q    <= 2'b11;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_addr_q <= 2'd0;
      rddat_q   <= 8'h00;
      irq_q     <= 1'b0;
    end else begin
      if (flush) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + AW'(1);
        if (pop)  rp_q <= rp_q + AW'(1);
        cnt_q <= cnt_q + NW'(push) - NW'(pop);
      end
      if (clr_ovf) ovf_q <= 1'b0;
      if (push_req && !flush && !push) ovf_q <= 1'b1;
      if (wr_rise && addr == 2'd2) ctrl_q <= wrdat[1:0];
      rd_q      <= rd_act;
      wr_q      <= wr_act;
      if (rd_act) rd_addr_q <= addr;
      rddat_q   <= rd_act ? rd_mux : 8'h00;
      irq_q     <= ctrl_q[1] & (~empty | ovf_q);
    end
  end

  assign rddat = rddat_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner (4x4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=8).
// Release-event expectations switch on KEY_RELEASE_EN.
module tb_key_matrix_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2, FIFO_DEPTH = 8;
  localparam int SCAN = COLS * SCAN_DIV;

  logic            clk = 1'b0, rst_n = 1'b0, cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [1:0]      addr = 2'd0;
  logic [7:0]      wrdat = 8'h00;
  logic [7:0]      rddat;
  logic            irq;
  logic [COLS-1:0] key_col_o;
  logic [ROWS-1:0] key_row_i;
  logic [ROWS*COLS-1:0] keys = '0;
  int n_cmp = 0, n_bad = 0;

  key_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                       .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .wrdat(wrdat), .rddat(rddat), .irq(irq), .key_col_o(key_col_o),
    .key_row_i(key_row_i));

  always #5 clk = ~clk;

  // Switch matrix: a row reads low when a pressed key sits on a driven-low column.
  always_comb begin
    key_row_i = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !key_col_o[c]) key_row_i[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk); d = rddat; cs = 1'b0; rd = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; wrdat = v;
    @(negedge clk); cs = 1'b0; wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  task automatic wait_col0(output logic ok);
    logic [COLS-1:0] prev;
    ok = 1'b0;
    for (int i = 0; i < 3 * SCAN; i++) begin
      prev = key_col_o;
      @(negedge clk);
      if (key_col_o == 4'b1110 && prev != 4'b1110) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic tap_key(input int k);
    keys[k] = 1'b1; wait_scans(5);
    keys[k] = 1'b0; wait_scans(5);
  endtask

  initial begin
    logic ok;
    logic [7:0] pat [5];
    pat[0] = 8'h0E; pat[1] = 8'h0D; pat[2] = 8'h0B; pat[3] = 8'h07; pat[4] = 8'h0E;

    repeat (3) @(negedge clk);
    check("rst_col", {4'h0, key_col_o}, 8'h0F);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_rddat", rddat, 8'h00);
    rst_n = 1'b1;

    wait_col0(ok);
    check("col0_seen", {7'd0, ok}, 8'h01);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("col_step%0d", i), {4'h0, key_col_o}, pat[i]);
      repeat (SCAN_DIV) @(negedge clk);
    end
    check("idle_irq", {7'd0, irq}, 8'h00);
    check("idle_rddat", rddat, 8'h00);
    expect_rd("status_rst", 2'd1, 8'h20);
    expect_rd("ctrl_rst", 2'd2, 8'h03);
    expect_rd("cmd_rd", 2'd3, 8'h00);

    // single key row1/col2
    keys[6] = 1'b1; wait_scans(5);
    check("k6_irq", {7'd0, irq}, 8'h01);
    expect_rd("k6_status", 2'd1, 8'h01);
    expect_rd("k6_data", 2'd0, 8'h06);
    expect_rd("k6_status_after", 2'd1, 8'h20);
    check("k6_irq_fall", {7'd0, irq}, 8'h00);
    keys[6] = 1'b0; wait_scans(5);
`ifdef KEY_RELEASE_EN
    expect_rd("k6_rel_data", 2'd0, 8'h86);
`endif
    expect_rd("k6_rel_status", 2'd1, 8'h20);

    // ghost: two keys together
    keys[0] = 1'b1; keys[15] = 1'b1; wait_scans(5);
    expect_rd("ghost_status", 2'd1, 8'h20);
    keys[0] = 1'b0; keys[15] = 1'b0; wait_scans(5);
    expect_rd("ghost_rel_status", 2'd1, 8'h20);
    keys[5] = 1'b1; wait_scans(5);
    expect_rd("k5_data", 2'd0, 8'h05);
    keys[5] = 1'b0; wait_scans(5);
`ifdef KEY_RELEASE_EN
    expect_rd("k5_rel_data", 2'd0, 8'h85);
`endif
    expect_rd("k5_empty", 2'd0, 8'hFF);

    // bounce: toggle key 9 every scan
    for (int i = 0; i < 8; i++) begin
      wait_col0(ok);
      keys[9] = ~keys[9];
    end
    check("bounce_sync", {7'd0, ok}, 8'h01);
    keys[9] = 1'b0; wait_scans(2);
    expect_rd("bounce_status", 2'd1, 8'h20);
    keys[9] = 1'b1; wait_scans(5);
    expect_rd("hold_status", 2'd1, 8'h01);
    expect_rd("hold_data", 2'd0, 8'h09);
    keys[9] = 1'b0; wait_scans(5);
`ifdef KEY_RELEASE_EN
    expect_rd("hold_rel_data", 2'd0, 8'h89);
`endif

    // scanning disabled
    bus_wr(2'd2, 8'h02);
    check("dis_col", {4'h0, key_col_o}, 8'h0F);
    expect_rd("dis_ctrl", 2'd2, 8'h02);
    keys[3] = 1'b1; wait_scans(5);
    check("dis_col_held", {4'h0, key_col_o}, 8'h0F);
    expect_rd("dis_status", 2'd1, 8'h20);
    keys[3] = 1'b0;
    bus_wr(2'd2, 8'h03);
    wait_scans(3);
    expect_rd("reen_status", 2'd1, 8'h20);

    // overflow: 9 taps, no reads
    for (int k = 0; k < 9; k++) tap_key(k);
    expect_rd("ovf_status", 2'd1, 8'hC8);
    check("ovf_irq", {7'd0, irq}, 8'h01);
    expect_rd("ovf_head", 2'd0, 8'h00);
    expect_rd("ovf_status_pop", 2'd1, 8'h87);
    bus_wr(2'd3, 8'h03);
    expect_rd("flush_status", 2'd1, 8'h20);
    check("flush_irq", {7'd0, irq}, 8'h00);
    expect_rd("empty_data", 2'd0, 8'hFF);
    expect_rd("empty_status", 2'd1, 8'h20);

    // irq gating
    bus_wr(2'd2, 8'h01);
    keys[2] = 1'b1; wait_scans(5);
    check("irqen0_irq", {7'd0, irq}, 8'h00);
    expect_rd("irqen0_status", 2'd1, 8'h01);
    bus_wr(2'd2, 8'h03);
    check("irqen1_irq", {7'd0, irq}, 8'h01);

    // reset mid-scan while a read strobe is held
    @(negedge clk); cs = 1'b1; rd = 1'b1; addr = 2'd1;
    @(negedge clk);
    check("pre_rst_rddat", rddat, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_col", {4'h0, key_col_o}, 8'h0F);
    check("mid_rst_irq", {7'd0, irq}, 8'h00);
    check("mid_rst_rddat", rddat, 8'h00);
    @(negedge clk); cs = 1'b0; rd = 1'b0; keys = '0;
    @(negedge clk); rst_n = 1'b1;
    expect_rd("post_rst_status", 2'd1, 8'h20);
    expect_rd("post_rst_ctrl", 2'd2, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
- Parametrised successor to the fixed 4x4 keypad block.
- Scans a ROWS x COLS switch matrix, debounces it, and queues key events in a small FIFO.
- Exposes DATA/STATUS/CTRL registers to the chip-select bus decoder and raises irq while events are pending.
- Sits behind one cs line of the bus decoder. Its rddat feeds the decoder's read mux.

Parameters:
- ROWS, 4, number of sensed row lines (1..8)
- COLS, 4, number of driven column lines (1..16); ROWS*COLS must be <= 128
- SCAN_DIV, 50000, clk cycles per column slot (1 ms at 50 MHz); must be >= 2
- DEBOUNCE, 4, consecutive identical full scans required before a state change is accepted (1..15)
- FIFO_DEPTH, 8, event FIFO depth, power of two, 2..64

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  chip select from bus decoder, active high
- rd  in  1  read strobe, active high, qualified by cs
- wr  in  1  write strobe, active high, qualified by cs
- addr  in  2  register select
- wrdat  in  8  write data
- rddat  out  8  registered read data
- irq  out  1  interrupt, active high, level
- key_col_o  out  COLS  column drive, active low, one-hot-low while scanning
- key_row_i  in  ROWS  row sense, externally pulled up, low = pressed

Behaviour:
Reset:
- key_col_o all ones, rddat 0x00, irq 0.
- FIFO empty, overflow 0, CTRL = 0x03 (enable=1, irq_en=1).
- Scan column 0, slot counter 0, debounce state "no key".
- Reset is legal at any time, including mid-scan or mid-read.

Scan:
- When CTRL.enable=1, column c is driven low for SCAN_DIV cycles; all other columns are held high.
- key_row_i is synchronised through a 2-flop synchroniser and sampled in the last cycle of the slot.
- Column index then advances, wrapping from COLS-1 to 0.
- When CTRL.enable=0, key_col_o = all ones, the counters hold at 0, and no events are generated. The FIFO stays readable.

Scan evaluation (after each complete scan, on wrap to column 0):
- Exactly one asserted key -> candidate = row*COLS+col.
- Zero asserted keys -> candidate = NONE.
- Two or more asserted keys -> candidate = NONE (ghost rejection).

Debounce:
- If candidate equals the previous scan's candidate, stable_cnt increments, saturating at DEBOUNCE. Otherwise stable_cnt resets to 1.
- When stable_cnt reaches DEBOUNCE and candidate differs from the accepted state, the accepted state becomes candidate.
- If the new accepted state is a key, a press event {1'b0, code[6:0]} is pushed.
- A change key A -> key B with no NONE in between pushes B's press event.

FIFO:
- Push when full: event dropped, STATUS.overflow set (sticky).
- Push and pop in the same cycle: both happen and count is unchanged; this is legal even when full.

Register map (accesses with cs=0 are ignored):
- addr 0, DATA (read): FIFO head, or 0xFF when empty.
  - Pop occurs in the cycle after cs&rd deasserts (falling edge of cs&rd), once per read strobe.
  - No pop when empty.
- addr 1, STATUS (read): {overflow, full, empty, count[4:0] saturated at 31}.
- addr 2, CTRL (read/write): bit0 enable, bit1 irq_en; other bits read 0.
- addr 3, CMD (write): bit0=1 clears overflow, bit1=1 flushes the FIFO. Reads return 0x00.
- Writes act on the cycle cs&wr is first seen high (rising edge), once per strobe.
- rddat = selected register, registered one cycle after cs&rd is high; 0x00 when cs&rd is low.

irq:
- Registered: irq = irq_en & (~empty | overflow).
- Falls one cycle after the pop that empties the FIFO (provided overflow is clear).

Optional Feature:
- Macro: KEY_RELEASE_EN.
- Defined: when the accepted state goes from key K to NONE or to another key, a release event {1'b1, K[6:0]} is pushed first. On A -> B the release of A is pushed, then the press of B on the following cycle. Each push is subject to full/overflow rules.
- Not defined: only press events are generated; bit7 of event data is always 0.

Test Plan:
- Reset, bench SCAN_DIV=4, DEBOUNCE=2 -> key_col_o steps 1110, 1101, 1011, 0111 every 4 clk; irq=0; STATUS read = 0x20.
- Hold row1/col2 pressed for 3 scans -> exactly one push; irq=1; DATA read = 0x06; after the strobe ends, STATUS = 0x20 and irq falls.
- Press row0/col0 and row3/col3 together -> no event (ghost); release both, then press key 5 alone -> DATA = 0x05.
- Toggle a key every scan (bounce), DEBOUNCE=2 -> no event; then hold it -> one event.
- Generate 9 presses with FIFO_DEPTH=8 and no reads -> STATUS = 0xC8 (overflow, full, count 8).
  - Write CMD=0x03 -> STATUS = 0x20, irq = 0.
  - Read DATA when empty -> 0xFF, no underflow.
- KEY_RELEASE_EN: press then release key 0x0A -> DATA reads 0x0A then 0x8A. Assert rst_n low mid-scan -> all outputs return to reset values immediately.
